// File: rtl/nios_pio_arbiter.sv
// Two-requester round-robin arbiter in front of a single Nios-style PIO slave.
// Optional grant locking is enabled by defining NIOS_PIO_ARB_LOCK_EN.
module nios_pio_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_write,
  input  logic              m0_read,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_write,
  input  logic              m1_read,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
`ifdef NIOS_PIO_ARB_LOCK_EN
  input  logic              m0_lock,
  input  logic              m1_lock,
`endif
  output logic [ADDR_W-1:0] address,
  output logic              chipselect,
  output logic              write_n,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata,
  output logic [1:0]        fsm_state
);

  // Handshake: a requester raises read/write and holds address/data until its
  // waitrequest drops; the access completes in that single cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   last_grant;
  logic   last_grant_next;
  logic   pend0;
  logic   pend1;
  logic   lock_active;
  logic   lock_owner;

  assign pend0     = m0_write | m0_read;
  assign pend1     = m1_write | m1_read;
  assign fsm_state = state;

`ifdef NIOS_PIO_ARB_LOCK_EN
  logic lock_active_next;
  logic lock_owner_next;

  always_comb begin
    lock_active_next = lock_active;
    lock_owner_next  = lock_owner;
    case (state)
      GRANT0: begin
        if (m0_lock) begin
          lock_active_next = 1'b1;
          lock_owner_next  = 1'b0;
        end else if (lock_active && !lock_owner) begin
          lock_active_next = 1'b0;
        end
      end
      GRANT1: begin
        if (m1_lock) begin
          lock_active_next = 1'b1;
          lock_owner_next  = 1'b1;
        end else if (lock_active && lock_owner) begin
          lock_active_next = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_active <= 1'b0;
      lock_owner  <= 1'b0;
    end else begin
      lock_active <= lock_active_next;
      lock_owner  <= lock_owner_next;
    end
  end
`else
  assign lock_active = 1'b0;
  assign lock_owner  = 1'b0;
`endif

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    case (state)
      IDLE: begin
        if (lock_active) begin
          // The lock owner is the only requester that may be granted.
          if (!lock_owner && pend0) begin
            state_next = GRANT0;
          end else if (lock_owner && pend1) begin
            state_next = GRANT1;
          end
        end else if (pend0 && pend1) begin
          state_next = last_grant ? GRANT0 : GRANT1;
        end else if (pend0) begin
          state_next = GRANT0;
        end else if (pend1) begin
          state_next = GRANT1;
        end
      end
      GRANT0: begin
        state_next      = IDLE;
        last_grant_next = 1'b0;
      end
      GRANT1: begin
        state_next      = IDLE;
        last_grant_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  // PIO outputs follow the granted requester combinationally, so a reset edge
  // arriving during a grant does not cancel that cycle's access.
  always_comb begin
    address        = '0;
    chipselect     = 1'b0;
    write_n        = 1'b1;
    writedata      = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    m0_readdata    = '0;
    m1_readdata    = '0;
    case (state)
      GRANT0: begin
        address        = m0_address;
        writedata      = m0_writedata;
        chipselect     = pend0;
        write_n        = ~m0_write;
        m0_waitrequest = 1'b0;
        m0_readdata    = readdata;
      end
      GRANT1: begin
        address        = m1_address;
        writedata      = m1_writedata;
        chipselect     = pend1;
        write_n        = ~m1_write;
        m1_waitrequest = 1'b0;
        m1_readdata    = readdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nios_pio_arbiter.sv
// Directed and randomized checks of nios_pio_arbiter against a grant-level
// reference model; define NIOS_PIO_ARB_LOCK_EN to also exercise locking.
module tb_nios_pio_arbiter;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] m0_address, m1_address;
  logic              m0_write, m0_read, m1_write, m1_read;
  logic [DATA_W-1:0] m0_writedata, m1_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
`ifdef NIOS_PIO_ARB_LOCK_EN
  logic              m0_lock, m1_lock;
`endif
  logic [ADDR_W-1:0] address;
  logic              chipselect, write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic [1:0]        fsm_state;

  int checks   = 0;
  int failures = 0;

  // Reference model: which requester (-1 none) owns the current cycle, who
  // was served last, and who holds the lock (-1 none).
  int m_grant;
  int m_last;
  int m_lock;

  always #5 clk = ~clk;

  nios_pio_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .m0_address     (m0_address),
    .m0_write       (m0_write),
    .m0_read        (m0_read),
    .m0_writedata   (m0_writedata),
    .m0_waitrequest (m0_waitrequest),
    .m0_readdata    (m0_readdata),
    .m1_address     (m1_address),
    .m1_write       (m1_write),
    .m1_read        (m1_read),
    .m1_writedata   (m1_writedata),
    .m1_waitrequest (m1_waitrequest),
    .m1_readdata    (m1_readdata),
`ifdef NIOS_PIO_ARB_LOCK_EN
    .m0_lock        (m0_lock),
    .m1_lock        (m1_lock),
`endif
    .address        (address),
    .chipselect     (chipselect),
    .write_n        (write_n),
    .writedata      (writedata),
    .readdata       (readdata),
    .fsm_state      (fsm_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    m0_address = '0; m0_write = 1'b0; m0_read = 1'b0; m0_writedata = '0;
    m1_address = '0; m1_write = 1'b0; m1_read = 1'b0; m1_writedata = '0;
    readdata = '0;
`ifdef NIOS_PIO_ARB_LOCK_EN
    m0_lock = 1'b0; m1_lock = 1'b0;
`endif
  endtask

  task automatic model_check();
    logic [63:0] e_addr, e_wd, e_rd0, e_rd1;
    logic        e_cs, e_wn, e_w0, e_w1;
    e_addr = '0; e_wd = '0; e_rd0 = '0; e_rd1 = '0;
    e_cs = 1'b0; e_wn = 1'b1; e_w0 = 1'b1; e_w1 = 1'b1;
    if (m_grant == 0) begin
      e_addr = 64'(m0_address); e_wd = 64'(m0_writedata);
      e_cs = m0_write | m0_read; e_wn = !m0_write; e_w0 = 1'b0; e_rd0 = 64'(readdata);
    end else if (m_grant == 1) begin
      e_addr = 64'(m1_address); e_wd = 64'(m1_writedata);
      e_cs = m1_write | m1_read; e_wn = !m1_write; e_w1 = 1'b0; e_rd1 = 64'(readdata);
    end
    check("mdl_address", 64'(address), e_addr);
    check("mdl_chipselect", 64'(chipselect), 64'(e_cs));
    check("mdl_write_n", 64'(write_n), 64'(e_wn));
    check("mdl_writedata", 64'(writedata), e_wd);
    check("mdl_m0_wait", 64'(m0_waitrequest), 64'(e_w0));
    check("mdl_m1_wait", 64'(m1_waitrequest), 64'(e_w1));
    check("mdl_m0_readdata", 64'(m0_readdata), e_rd0);
    check("mdl_m1_readdata", 64'(m1_readdata), e_rd1);
  endtask

  // Called just after a rising edge; inputs are unchanged since that edge.
  task automatic model_update();
    bit p0, p1;
    p0 = m0_write | m0_read;
    p1 = m1_write | m1_read;
    if (reset) begin
      m_grant = -1; m_last = 1; m_lock = -1;
    end else if (m_grant != -1) begin
`ifdef NIOS_PIO_ARB_LOCK_EN
      if ((m_grant == 0) ? m0_lock : m1_lock) m_lock = m_grant;
      else if (m_lock == m_grant) m_lock = -1;
`endif
      m_last  = m_grant;
      m_grant = -1;
    end else if (m_lock != -1) begin
      m_grant = ((m_lock == 0) ? p0 : p1) ? m_lock : -1;
    end else if (p0 && p1) begin
      m_grant = 1 - m_last;
    end else if (p0) begin
      m_grant = 0;
    end else if (p1) begin
      m_grant = 1;
    end
  endtask

  // Inputs are changed only at falling edges; outputs are sampled mid-low-phase.
  task automatic tick();
    #2;
    model_check();
    @(posedge clk);
    #0 model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int exp_rr[8];
    clear_inputs();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_grant = -1; m_last = 1; m_lock = -1;

    // Reset state
    #1;
    check("rst_chipselect", 64'(chipselect), 64'(0));
    check("rst_write_n", 64'(write_n), 64'(1));
    check("rst_m0_wait", 64'(m0_waitrequest), 64'(1));
    check("rst_m1_wait", 64'(m1_waitrequest), 64'(1));
    tick();
    reset = 1'b0;

    // Single write from requester 0
    m0_write = 1'b1; m0_address = '0; m0_writedata = 32'hA5;
    #1;
    check("wr0_idle_cs", 64'(chipselect), 64'(0));
    check("wr0_idle_wait", 64'(m0_waitrequest), 64'(1));
    tick();
    #1;
    check("wr0_cs", 64'(chipselect), 64'(1));
    check("wr0_write_n", 64'(write_n), 64'(0));
    check("wr0_writedata", 64'(writedata), 64'h0A5);
    check("wr0_wait", 64'(m0_waitrequest), 64'(0));
    tick();
    clear_inputs();
    #1;
    check("wr0_after_wait", 64'(m0_waitrequest), 64'(1));
    tick();

    // Single read from requester 1
    m1_read = 1'b1; m1_address = 2'd2; readdata = 32'h3C;
    tick();
    #1;
    check("rd1_readdata", 64'(m1_readdata), 64'h3C);
    check("rd1_wait", 64'(m1_waitrequest), 64'(0));
    check("rd1_m0_wait", 64'(m0_waitrequest), 64'(1));
    check("rd1_address", 64'(address), 64'(2));
    check("rd1_write_n", 64'(write_n), 64'(1));
    tick();
    clear_inputs();
    tick();

    // Both requesters writing continuously from reset
    do_reset();
    m0_write = 1'b1; m1_write = 1'b1;
    m0_writedata = 32'h1111; m1_writedata = 32'h2222;
    exp_rr = '{-1, 0, -1, 1, -1, 0, -1, 1};
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("rr_m0_wait_%0d", i), 64'(m0_waitrequest), 64'(exp_rr[i] != 0));
      check($sformatf("rr_m1_wait_%0d", i), 64'(m1_waitrequest), 64'(exp_rr[i] != 1));
      tick();
    end

    // Reset during a GRANT0 cycle with both pending
    do_reset();
    tick();
    reset = 1'b1;
    #1;
    check("rstg_cs_kept", 64'(chipselect), 64'(1));
    check("rstg_m0_wait", 64'(m0_waitrequest), 64'(0));
    tick();
    reset = 1'b0;
    #1;
    check("rstg_idle_m0", 64'(m0_waitrequest), 64'(1));
    check("rstg_idle_m1", 64'(m1_waitrequest), 64'(1));
    check("rstg_idle_cs", 64'(chipselect), 64'(0));
    tick();
    #1;
    check("rstg_regrant0", 64'(m0_waitrequest), 64'(0));
    check("rstg_m1_waits", 64'(m1_waitrequest), 64'(1));
    tick();
    clear_inputs();
    tick();

    // Withdrawn request during its grant cycle
    m1_write = 1'b1;
    tick();
    m1_write = 1'b0;
    #1;
    check("wd_cs", 64'(chipselect), 64'(0));
    tick();
    tick();

`ifdef NIOS_PIO_ARB_LOCK_EN
    // Locked burst from requester 0 while requester 1 waits
    do_reset();
    m0_write = 1'b1; m1_write = 1'b1;
    exp_rr = '{-1, 0, -1, 0, -1, 0, -1, 0};
    for (int i = 0; i < 10; i++) begin
      m0_lock = (i < 6);
      #1;
      if (i < 8) begin
        check($sformatf("lk_m0_wait_%0d", i), 64'(m0_waitrequest), 64'(exp_rr[i] != 0));
        check($sformatf("lk_m1_wait_%0d", i), 64'(m1_waitrequest), 64'(1));
      end else begin
        check($sformatf("lk_m1_wait_%0d", i), 64'(m1_waitrequest), 64'(i != 9));
      end
      tick();
    end
    clear_inputs();
    tick();
`endif

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 29) == 0);
      m0_write = 1'($urandom_range(0, 2) == 0);
      m0_read  = 1'($urandom_range(0, 2) == 0);
      m1_write = 1'($urandom_range(0, 2) == 0);
      m1_read  = 1'($urandom_range(0, 2) == 0);
      m0_address = ADDR_W'($urandom());
      m1_address = ADDR_W'($urandom());
      m0_writedata = $urandom();
      m1_writedata = $urandom();
      readdata = $urandom();
`ifdef NIOS_PIO_ARB_LOCK_EN
      m0_lock = 1'($urandom_range(0, 1));
      m1_lock = 1'($urandom_range(0, 1));
`endif
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
